// File: rtl/pit_pkg.sv
// Shared constants and types for the 8254 counter channel blocks.
package pit_pkg;

  typedef enum logic [2:0] {
    MODE0 = 3'd0,
    MODE1 = 3'd1,
    MODE2 = 3'd2,
    MODE3 = 3'd3,
    MODE4 = 3'd4,
    MODE5 = 3'd5
  } mode_e;

  localparam logic [1:0]  SEL_LSB = 2'b01;
  localparam logic [1:0]  SEL_MSB = 2'b10;
  localparam logic [15:0] BIN_MAX = 16'hFFFF;
  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Square-wave mode counts down by two; bits [3:1] of the status byte hold the mode.
  function automatic logic is_step2(input logic [7:0] status);
    return status[3:1] == MODE3;
  endfunction

endpackage

// File: rtl/count_decrementer.sv
// Combinational binary/BCD decrement by 1 or 2 with natural wrap-around.
module count_decrementer
  import pit_pkg::*;
(
  input  logic [15:0] value,
  input  logic        bcd,
  input  logic        step2,
  output logic [15:0] next
);

  logic [3:0] nib;
  logic [3:0] take;

  always_comb begin
    next = '0;
    nib  = '0;
    take = step2 ? 4'd2 : 4'd1;
    if (!bcd) begin
      next = value - {14'd0, step2, ~step2};
    end else begin
      // A nibble smaller than the amount taken wraps by ten and borrows from the next one;
      // A-F nibbles just subtract, uncorrected.
      for (int unsigned i = 0; i < 4; i++) begin
        nib = value[i*4 +: 4];
        if (nib < take) begin
          next[i*4 +: 4] = nib + 4'd10 - take;
          take = 4'd1;
        end else begin
          next[i*4 +: 4] = nib - take;
          take = 4'd0;
        end
      end
    end
  end

endmodule

// File: rtl/counting_element.sv
// 8254 counter channel datapath: count register, counting element, output latch and read bus.
module counting_element
  import pit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic [1:0]       CR_enable,
  input  logic             CR_reset,
  input  logic             load_new_count,
  input  logic             count_enable,
  input  logic [7:0]       status_byte,
  input  logic [1:0]       OL_enable,
  input  logic [1:0]       read_count_enable,
  input  logic             read_status_enable,
  output logic [WIDTH-1:0] current_count,
  output logic [WIDTH-1:0] initial_count,
  output logic             count_loaded,
  output logic [7:0]       data_out
);

  logic [WIDTH-1:0] cr, ce, ol, ce_dec;
  logic             step2, cr_write;

  assign step2    = is_step2(status_byte);
  assign cr_write = (CR_enable == SEL_LSB) || (CR_enable == SEL_MSB);

  count_decrementer u_dec (
    .value (ce),
    .bcd   (status_byte[0]),
    .step2 (step2),
    .next  (ce_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr <= '0;
    end else if (CR_enable == SEL_LSB) begin
      cr[7:0] <= data_in;
    end else if (CR_enable == SEL_MSB) begin
      cr[15:8] <= data_in;
    end
  end

  // Load samples the pre-write CR, so a same-edge write leaves CE on the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce <= '0;
    end else if (load_new_count) begin
      ce <= step2 ? {cr[15:1], 1'b0} : cr;
    end else if (count_enable) begin
      ce <= ce_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_loaded <= 1'b0;
    end else if (CR_reset || cr_write) begin
      count_loaded <= 1'b0;
    end else if (load_new_count) begin
      count_loaded <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ol <= '0;
    end else begin
      if (OL_enable[0]) ol[7:0]  <= ce[7:0];
      if (OL_enable[1]) ol[15:8] <= ce[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (read_status_enable) begin
      data_out <= status_byte;
    end else if (read_count_enable == SEL_LSB) begin
      data_out <= ol[7:0];
    end else if (read_count_enable == SEL_MSB) begin
      data_out <= ol[15:8];
    end else begin
      data_out <= '0;
    end
  end

  assign current_count = ce;
  assign initial_count = cr;

endmodule
